srate_map_arbiter: RTL and testbench

- Shares one single-port, synchronous-read shading-rate BRAM between NUM_RD VRS-controller lookup ports and one map-update write port.
- The map is double-buffered. Lookups read the front bank. Foveation/application updates write the back bank.
- A swap request flips the banks at a safe boundary, so the raster front-end never sees a half-updated shading-rate image.

---
 rtl/srate_map_arbiter.sv | 156 +++++++++++++++
 tb/tb_srate_map_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srate_map_arbiter.sv
// Arbitrates one single-port shading-rate BRAM between NUM_RD lookup ports and one
// map-update port, with a double-buffered map whose banks flip on a swap request.
module srate_map_arbiter #(
  parameter int TILE_ADDR_BITS = 13,
  parameter int SRATE_WIDTH    = 2,
  parameter int NUM_RD         = 4,
  parameter int WR_STARVE_MAX  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RD-1:0]                rd_req_valid,
  output logic [NUM_RD-1:0]                rd_req_ready,
  input  logic [NUM_RD*TILE_ADDR_BITS-1:0] rd_req_addr,
  output logic [NUM_RD-1:0]                rd_resp_valid,
  output logic [SRATE_WIDTH-1:0]           rd_resp_data,
  input  logic                             wr_req_valid,
  output logic                             wr_req_ready,
  input  logic [TILE_ADDR_BITS-1:0]        wr_req_addr,
  input  logic [SRATE_WIDTH-1:0]           wr_req_data,
  input  logic                             swap_req,
  output logic                             swap_done,
  output logic                             front_bank,
  output logic                             bram_en,
  output logic                             bram_we,
  output logic [TILE_ADDR_BITS:0]          bram_addr,
  output logic [SRATE_WIDTH-1:0]           bram_din,
  input  logic [SRATE_WIDTH-1:0]           bram_dout
);

  localparam int PTR_W = $clog2(NUM_RD);
  localparam int CNT_W = $clog2(WR_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(WR_STARVE_MAX);
  localparam logic [PTR_W:0]   NUM_RD_W     = (PTR_W + 1)'(NUM_RD);
  localparam logic [PTR_W-1:0] LAST_RD      = PTR_W'(NUM_RD - 1);

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

  swap_state_t              swap_state_reg, swap_state_next;
  logic [PTR_W-1:0]         rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]         starve_cnt_reg, starve_cnt_next;
  logic                     front_bank_reg;
  logic                     swap_done_reg;
  logic [NUM_RD-1:0]        resp_valid_reg;

  logic                     any_rd;
  logic                     wr_grant;
  logic                     rd_grant;
  logic                     rd_found;
  logic [PTR_W-1:0]         rd_sel;
  logic [PTR_W:0]           cand;
  logic                     swap_apply;
  logic [TILE_ADDR_BITS-1:0] rd_addr_arr [NUM_RD];

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
      assign rd_addr_arr[gi]  = rd_req_addr[gi*TILE_ADDR_BITS +: TILE_ADDR_BITS];
      assign rd_req_ready[gi] = rd_grant && (rd_sel == PTR_W'(gi));
    end
  endgenerate

  // Write wins when no reader wants the port or once it has been starved long enough.
  always_comb begin
    any_rd   = |rd_req_valid;
    wr_grant = rst_n && wr_req_valid && (!any_rd || (starve_cnt_reg == STARVE_LIMIT));
    rd_grant = rst_n && !wr_grant && any_rd;
    rd_found = 1'b0;
    rd_sel   = '0;
    cand     = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      cand = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(k);
      if (cand >= NUM_RD_W) begin
        cand = cand - NUM_RD_W;
      end
      if (!rd_found && rd_req_valid[cand[PTR_W-1:0]]) begin
        rd_found = 1'b1;
        rd_sel   = cand[PTR_W-1:0];
      end
    end
  end

  // Lookups always see the front bank; updates always land in the back bank.
  always_comb begin
    bram_en   = wr_grant || rd_grant;
    bram_we   = wr_grant;
    bram_addr = '0;
    bram_din  = '0;
    if (wr_grant) begin
      bram_addr = {~front_bank_reg, wr_req_addr};
      bram_din  = wr_req_data;
    end else if (rd_grant) begin
      bram_addr = {front_bank_reg, rd_addr_arr[rd_sel]};
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (rd_grant) begin
      rr_ptr_next = (rd_sel == LAST_RD) ? '0 : rd_sel + 1'b1;
    end
    starve_cnt_next = starve_cnt_reg;
    if (wr_grant) begin
      starve_cnt_next = '0;
    end else if (wr_req_valid && (starve_cnt_reg != STARVE_LIMIT)) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  // A swap request arriving while one is already pending is simply absorbed.
  always_comb begin
    swap_state_next = swap_state_reg;
    swap_apply      = 1'b0;
    case (swap_state_reg)
      SWAP_IDLE: begin
        if (swap_req) begin
          swap_state_next = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (!wr_grant) begin
          swap_apply      = 1'b1;
          swap_state_next = SWAP_IDLE;
        end
      end
      default: swap_state_next = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      swap_state_reg <= SWAP_IDLE;
      rr_ptr_reg     <= '0;
      starve_cnt_reg <= '0;
      front_bank_reg <= 1'b0;
      swap_done_reg  <= 1'b0;
      resp_valid_reg <= '0;
    end else begin
      swap_state_reg <= swap_state_next;
      rr_ptr_reg     <= rr_ptr_next;
      starve_cnt_reg <= starve_cnt_next;
      front_bank_reg <= front_bank_reg ^ swap_apply;
      swap_done_reg  <= swap_apply;
      resp_valid_reg <= rd_req_ready;
    end
  end

  // A response still in flight when reset arrives must never reach a requester.
  assign rd_resp_valid = rst_n ? resp_valid_reg : '0;
  assign rd_resp_data  = (rst_n && (|resp_valid_reg)) ? bram_dout : '0;
  assign wr_req_ready  = wr_grant;
  assign front_bank    = front_bank_reg;
  assign swap_done     = swap_done_reg;

endmodule

// File: tb/tb_srate_map_arbiter.sv
// Bench for srate_map_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbiter and both map banks.
module tb_srate_map_arbiter;
  localparam int TAB = 13;
  localparam int SW  = 2;
  localparam int NRD = 4;
  localparam int WSM = 8;
  localparam int MEM_DEPTH = 1 << (TAB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NRD-1:0]     rd_req_valid;
  logic [NRD-1:0]     rd_req_ready;
  logic [NRD*TAB-1:0] rd_req_addr;
  logic [NRD-1:0]     rd_resp_valid;
  logic [SW-1:0]      rd_resp_data;
  logic               wr_req_valid;
  logic               wr_req_ready;
  logic [TAB-1:0]     wr_req_addr;
  logic [SW-1:0]      wr_req_data;
  logic               swap_req;
  logic               swap_done;
  logic               front_bank;
  logic               bram_en;
  logic               bram_we;
  logic [TAB:0]       bram_addr;
  logic [SW-1:0]      bram_din;
  logic [SW-1:0]      bram_dout;

  srate_map_arbiter #(
    .TILE_ADDR_BITS(TAB), .SRATE_WIDTH(SW), .NUM_RD(NRD), .WR_STARVE_MAX(WSM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .swap_req(swap_req), .swap_done(swap_done), .front_bank(front_bank),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  // Single-port synchronous-read BRAM
  logic [SW-1:0] bram_mem [0:MEM_DEPTH-1];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) bram_mem[bram_addr] <= bram_din;
      else         bram_dout <= bram_mem[bram_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [SW-1:0]  m_mem [0:MEM_DEPTH-1];
  bit             m_front;
  int             m_rr;
  int             m_starve;
  bit             m_pending;
  bit             m_swap_done;
  logic [NRD-1:0] m_resp_valid;
  logic [SW-1:0]  m_resp_data;

  logic [NRD-1:0] e_rd_ready;
  bit             e_wr_ready;
  bit             e_en;
  bit             e_we;
  logic [TAB:0]   e_addr;
  logic [SW-1:0]  e_din;
  int             e_rd_idx;

  function automatic void model_eval();
    int idx;
    e_rd_ready = '0; e_wr_ready = 0; e_en = 0; e_we = 0;
    e_addr = '0; e_din = '0; e_rd_idx = -1;
    if (!rst_n) return;
    if (wr_req_valid && (rd_req_valid == 0 || m_starve == WSM)) begin
      e_wr_ready = 1; e_en = 1; e_we = 1;
      e_addr = {~m_front, wr_req_addr};
      e_din = wr_req_data;
    end else if (rd_req_valid != 0) begin
      for (int k = 0; k < NRD; k++) begin
        idx = (m_rr + k) % NRD;
        if (e_rd_idx < 0 && rd_req_valid[idx]) e_rd_idx = idx;
      end
      e_rd_ready[e_rd_idx] = 1'b1;
      e_en = 1;
      e_addr = {m_front, rd_req_addr[e_rd_idx*TAB +: TAB]};
    end
  endfunction

  function automatic void model_update();
    bit apply;
    model_eval();
    if (!rst_n) begin
      m_front = 0; m_rr = 0; m_starve = 0; m_pending = 0;
      m_swap_done = 0; m_resp_valid = '0; m_resp_data = '0;
      return;
    end
    m_resp_valid = '0;
    m_resp_data = '0;
    if (e_wr_ready) begin
      m_mem[e_addr] = e_din;
      m_starve = 0;
    end else if (wr_req_valid && m_starve < WSM) begin
      m_starve++;
    end
    if (e_rd_idx >= 0) begin
      m_resp_valid[e_rd_idx] = 1'b1;
      m_resp_data = m_mem[e_addr];
      m_rr = (e_rd_idx + 1) % NRD;
    end
    apply = m_pending && !e_wr_ready;
    m_swap_done = apply;
    if (apply) begin
      m_front = ~m_front;
      m_pending = 0;
    end else if (swap_req) begin
      m_pending = 1;
    end
  endfunction

  function automatic logic [NRD-1:0] exp_resp_valid();
    return rst_n ? m_resp_valid : '0;
  endfunction

  function automatic logic [SW-1:0] exp_resp_data();
    return (rst_n && m_resp_valid != 0) ? m_resp_data : '0;
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    rd_req_valid = '0; rd_req_addr = '0;
    wr_req_valid = 0; wr_req_addr = '0; wr_req_data = '0; swap_req = 0;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_req_valid[i] = 1'b1;
    rd_req_addr[i*TAB +: TAB] = TAB'(a);
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    rd_req_valid = '1; wr_req_valid = 1; swap_req = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rd_req_ready !== 4'b0000 || wr_req_ready !== 1'b0 || bram_en !== 1'b0 || bram_we !== 1'b0) begin
        failures++;
        $display("FAIL reset_grants got rd=%b wr=%b en=%b we=%b exp all 0", rd_req_ready, wr_req_ready, bram_en, bram_we);
      end
      checks++;
      if (rd_resp_valid !== 4'b0000 || rd_resp_data !== 2'd0 || swap_done !== 1'b0 || front_bank !== 1'b0) begin
        failures++;
        $display("FAIL reset_state got rv=%b rd=%0d sd=%b fb=%b exp 0", rd_resp_valid, rd_resp_data, swap_done, front_bank);
      end
      tick();
    end
    drive_idle();
    rst_n = 1;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    drive_idle();
    set_rd(2, 'h005);
    #1;
    model_eval();
    checks++;
    if (rd_req_ready !== 4'b0100 || rd_req_ready !== e_rd_ready) begin
      failures++;
      $display("FAIL single_ready got=%b exp=0100", rd_req_ready);
    end
    checks++;
    if (bram_addr !== 14'h0005 || bram_en !== 1'b1 || bram_we !== 1'b0) begin
      failures++;
      $display("FAIL single_bram got addr=%h en=%b we=%b exp addr=0005 en=1 we=0", bram_addr, bram_en, bram_we);
    end
    tick();
    drive_idle();
    #1;
    checks++;
    if (rd_resp_valid !== 4'b0100 || rd_resp_data !== 2'd3) begin
      failures++;
      $display("FAIL single_resp got v=%b d=%0d exp v=0100 d=3", rd_resp_valid, rd_resp_data);
    end
    tick();
    $display("test_single_read done");
  endtask

  task automatic test_round_robin();
    logic [NRD-1:0] exp_oh;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      for (int i = 0; i < NRD; i++) set_rd(i, $urandom_range(0, MEM_DEPTH / 2 - 1));
      #1;
      model_eval();
      exp_oh = NRD'(1 << (c % NRD));
      checks++;
      if (rd_req_ready !== exp_oh || bram_addr !== e_addr) begin
        failures++;
        $display("FAIL rr_grant cycle=%0d got=%b addr=%h exp=%b addr=%h", c, rd_req_ready, bram_addr, exp_oh, e_addr);
      end
      if (c > 0) begin
        exp_oh = NRD'(1 << ((c - 1) % NRD));
        checks++;
        if (rd_resp_valid !== exp_oh || rd_resp_data !== exp_resp_data()) begin
          failures++;
          $display("FAIL rr_resp cycle=%0d got v=%b d=%0d exp v=%b d=%0d", c, rd_resp_valid, rd_resp_data, exp_oh, exp_resp_data());
        end
      end
      tick();
    end
    drive_idle();
    tick();
    $display("test_round_robin done");
  endtask

  task automatic test_starve();
    int granted_at = 0;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      for (int i = 0; i < NRD; i++) set_rd(i, $urandom_range(0, 255));
      wr_req_valid = 1; wr_req_addr = 'h010; wr_req_data = 2'd1;
      #1;
      model_eval();
      checks++;
      if (wr_req_ready !== e_wr_ready || rd_req_ready !== e_rd_ready || bram_addr !== e_addr) begin
        failures++;
        $display("FAIL starve_cycle n=%0d got wr=%b rd=%b addr=%h exp wr=%b rd=%b addr=%h",
                 n, wr_req_ready, rd_req_ready, bram_addr, e_wr_ready, e_rd_ready, e_addr);
      end
      if (wr_req_ready === 1'b1) begin
        granted_at = n;
        checks++;
        if (bram_addr !== 14'h2010 || bram_we !== 1'b1 || bram_din !== 2'd1) begin
          failures++;
          $display("FAIL starve_write got addr=%h we=%b din=%0d exp addr=2010 we=1 din=1", bram_addr, bram_we, bram_din);
        end
        tick();
        break;
      end
      tick();
    end
    checks++;
    if (granted_at != 9) begin
      failures++;
      $display("FAIL starve_latency got=%0d exp=9", granted_at);
    end
    wr_req_valid = 0;
    #1;
    model_eval();
    checks++;
    if (rd_req_ready !== 4'b0001 || rd_req_ready !== e_rd_ready) begin
      failures++;
      $display("FAIL starve_resume got=%b exp=0001", rd_req_ready);
    end
    tick();
    drive_idle();
    tick();
    $display("test_starve done");
  endtask

  task automatic test_swap();
    bit seen = 0;
    drive_idle();
    swap_req = 1;
    #1;
    tick();
    swap_req = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      #1;
      checks++;
      if (swap_done !== m_swap_done || front_bank !== m_front) begin
        failures++;
        $display("FAIL swap_wait c=%0d got sd=%b fb=%b exp sd=%b fb=%b", c, swap_done, front_bank, m_swap_done, m_front);
      end
      if (swap_done === 1'b1) seen = 1;
      tick();
    end
    checks++;
    if (!seen || front_bank !== 1'b1) begin
      failures++;
      $display("FAIL swap_flip got seen=%b fb=%b exp seen=1 fb=1", seen, front_bank);
    end
    set_rd(0, 'h010);
    #1;
    checks++;
    if (bram_addr !== 14'h2010) begin
      failures++;
      $display("FAIL swap_read_addr got=%h exp=2010", bram_addr);
    end
    tick();
    drive_idle();
    #1;
    checks++;
    if (rd_resp_valid !== 4'b0001 || rd_resp_data !== 2'd1) begin
      failures++;
      $display("FAIL swap_read_data got v=%b d=%0d exp v=0001 d=1", rd_resp_valid, rd_resp_data);
    end
    tick();
    $display("test_swap done");
  endtask

  task automatic test_swap_write();
    int wa;
    logic [SW-1:0] wd;
    int pulses = 0;
    wa = $urandom_range(32, 4095);
    wd = SW'($urandom_range(0, 3));
    do_reset();
    wr_req_valid = 1; wr_req_addr = TAB'(wa); wr_req_data = wd; swap_req = 1;
    #1;
    checks++;
    if (wr_req_ready !== 1'b1 || bram_addr !== {1'b1, TAB'(wa)}) begin
      failures++;
      $display("FAIL swapwr_grant got wr=%b addr=%h exp wr=1 addr=%h", wr_req_ready, bram_addr, {1'b1, TAB'(wa)});
    end
    tick();
    wr_req_valid = 0; swap_req = 1;
    #1;
    checks++;
    if (front_bank !== 1'b0 || swap_done !== 1'b0) begin
      failures++;
      $display("FAIL swapwr_defer got fb=%b sd=%b exp fb=0 sd=0", front_bank, swap_done);
    end
    tick();
    swap_req = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (swap_done === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 1 || front_bank !== 1'b1) begin
      failures++;
      $display("FAIL swapwr_once got pulses=%0d fb=%b exp pulses=1 fb=1", pulses, front_bank);
    end
    set_rd(1, wa);
    #1;
    tick();
    drive_idle();
    #1;
    checks++;
    if (rd_resp_valid !== 4'b0010 || rd_resp_data !== wd) begin
      failures++;
      $display("FAIL swapwr_readback got v=%b d=%0d exp v=0010 d=%0d", rd_resp_valid, rd_resp_data, wd);
    end
    tick();
    $display("test_swap_write done");
  endtask

  task automatic test_reset_mid();
    drive_idle();
    set_rd(3, $urandom_range(0, 4095));
    #1;
    checks++;
    if (rd_req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL midrst_grant got=%b exp=1000", rd_req_ready);
    end
    tick();
    drive_idle();
    rst_n = 0;
    #1;
    checks++;
    if (rd_resp_valid !== 4'b0000 || rd_resp_valid !== exp_resp_valid()) begin
      failures++;
      $display("FAIL midrst_drop got=%b exp=0000", rd_resp_valid);
    end
    tick();
    #1;
    checks++;
    if (front_bank !== 1'b0 || rd_resp_valid !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_state got fb=%b rv=%b exp fb=0 rv=0000", front_bank, rd_resp_valid);
    end
    rst_n = 1;
    rd_req_valid = '1;
    #1;
    checks++;
    if (rd_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_first got=%b exp=0001", rd_req_ready);
    end
    tick();
    drive_idle();
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      rd_req_valid = NRD'($urandom_range(0, 15));
      for (int i = 0; i < NRD; i++) rd_req_addr[i*TAB +: TAB] = TAB'($urandom_range(0, 31));
      wr_req_valid = ($urandom_range(0, 9) < 4);
      wr_req_addr = TAB'($urandom_range(0, 31));
      wr_req_data = SW'($urandom_range(0, 3));
      swap_req = ($urandom_range(0, 19) == 0);
      #1;
      model_eval();
      checks++;
      if (rd_req_ready !== e_rd_ready || wr_req_ready !== e_wr_ready) begin
        failures++;
        $display("FAIL rand_grant c=%0d got rd=%b wr=%b exp rd=%b wr=%b", c, rd_req_ready, wr_req_ready, e_rd_ready, e_wr_ready);
      end
      checks++;
      if (bram_en !== e_en || bram_we !== e_we || bram_addr !== e_addr || bram_din !== e_din) begin
        failures++;
        $display("FAIL rand_bram c=%0d got en=%b we=%b addr=%h din=%0d exp en=%b we=%b addr=%h din=%0d",
                 c, bram_en, bram_we, bram_addr, bram_din, e_en, e_we, e_addr, e_din);
      end
      checks++;
      if (rd_resp_valid !== exp_resp_valid() || rd_resp_data !== exp_resp_data()) begin
        failures++;
        $display("FAIL rand_resp c=%0d got v=%b d=%0d exp v=%b d=%0d", c, rd_resp_valid, rd_resp_data, exp_resp_valid(), exp_resp_data());
      end
      checks++;
      if (swap_done !== m_swap_done || front_bank !== m_front) begin
        failures++;
        $display("FAIL rand_swap c=%0d got sd=%b fb=%b exp sd=%b fb=%b", c, swap_done, front_bank, m_swap_done, m_front);
      end
      tick();
    end
    rst_n = 1;
    drive_idle();
    tick();
    $display("test_random done");
  endtask

  initial begin
    logic [SW-1:0] v;
    for (int a = 0; a < MEM_DEPTH; a++) begin
      v = SW'($urandom_range(0, 3));
      bram_mem[a] = v;
      m_mem[a] = v;
    end
    bram_mem[5] = 2'd3;
    m_mem[5] = 2'd3;
    drive_idle();
    rst_n = 0;
    @(negedge clk);
    tick();
    test_reset();
    test_single_read();
    test_round_robin();
    test_starve();
    test_swap();
    test_swap_write();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
